// File: rtl/game_controller_pkg.sv
// Shared definitions for the memory game controller.
// Holds the FSM encoding, the LFSR constants and the round-length formula.
package game_controller_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_GEN,
    S_SHOW_ON,
    S_SHOW_OFF,
    S_CLR,
    S_CAPTURE,
    S_CHECK,
    S_PASS,
    S_FAIL
  } state_t;

  // Right-shifting Fibonacci form of taps 16,14,13,11: feedback is taken from bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS     = 16'h002D;
  localparam logic [15:0] ZERO_SEED_SUB = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {^(cur & LFSR_TAPS), cur[15:1]};
  endfunction

  function automatic logic [2:0] next_elem(input logic [15:0] cur);
    logic [15:0] nxt;
    nxt = lfsr_next(cur);
    return nxt[2:0];
  endfunction

  function automatic logic [4:0] round_len(input logic [2:0] level);
    return {level, 2'b00} + 5'd4;
  endfunction

endpackage

// File: rtl/game_lfsr16.sv
// 16-bit Fibonacci LFSR used to generate the round pattern.
// A zero seed would lock the register, so it is swapped for a fixed non-zero value.
module game_lfsr16
  import game_controller_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] out
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out <= '0;
    end else if (load) begin
      out <= (seed == 16'h0000) ? ZERO_SEED_SUB : seed;
    end else if (step) begin
      out <= lfsr_next(out);
    end
  end

endmodule

// File: rtl/game_controller.sv
// Memory game round controller: generates a pseudo-random pattern, displays it,
// lets the capture block record the player's presses, then checks them.
module game_controller
  import game_controller_pkg::*;
#(
  parameter int SHOW_ON  = 8,
  parameter int SHOW_OFF = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  level,
  input  logic [15:0] seed,
  input  logic [47:0] cap_data,
  input  logic        cap_done,
  output logic        cap_enable,
  output logic        cap_clr_n,
  output logic        show_valid,
  output logic [2:0]  show_idx,
  output logic        busy,
  output logic        pass,
  output logic        fail,
  output logic [7:0]  score
);

  localparam logic [15:0] ON_LAST  = 16'(SHOW_ON - 1);
  localparam logic [15:0] OFF_LAST = 16'(SHOW_OFF - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

  state_t      state;
  logic [3:0]  idx;
  logic [3:0]  last_idx;
  logic [15:0] cnt;
  logic [2:0]  pattern  [16];
  logic [2:0]  cap_slot [16];
  logic [15:0] lfsr_out;
  logic        accept;
  logic        lfsr_step;

  assign accept    = (state == S_IDLE) && start && (level inside {3'd1, 3'd2, 3'd3});
  assign lfsr_step = (state == S_GEN);

  for (genvar k = 0; k < 16; k++) begin : g_slot
    assign cap_slot[k] = cap_data[3*k +: 3];
  end

  game_lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .seed (seed),
    .step (lfsr_step),
    .out  (lfsr_out)
  );

  // cnt is shared: show on/off timing in the display phase, timeout in capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      last_idx   <= '0;
      cnt        <= '0;
      for (int k = 0; k < 16; k++) pattern[k] <= '0;
      cap_enable <= 1'b0;
      cap_clr_n  <= 1'b0;
      show_valid <= 1'b0;
      show_idx   <= '0;
      busy       <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      score      <= '0;
    end else begin
      pass      <= 1'b0;
      fail      <= 1'b0;
      cap_clr_n <= 1'b1;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state    <= S_GEN;
            idx      <= '0;
            last_idx <= 4'(round_len(level) - 5'd1);
            busy     <= 1'b1;
          end
        end
        S_GEN: begin
          pattern[idx] <= next_elem(lfsr_out);
          if (idx == last_idx) begin
            state      <= S_SHOW_ON;
            idx        <= '0;
            cnt        <= '0;
            show_valid <= 1'b1;
            show_idx   <= pattern[0];
          end else begin
            idx <= idx + 4'd1;
          end
        end
        S_SHOW_ON: begin
          if (cnt == ON_LAST) begin
            state      <= S_SHOW_OFF;
            cnt        <= '0;
            show_valid <= 1'b0;
            show_idx   <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_SHOW_OFF: begin
          if (cnt == OFF_LAST) begin
            cnt <= '0;
            if (idx == last_idx) begin
              state     <= S_CLR;
              cap_clr_n <= 1'b0;
            end else begin
              state      <= S_SHOW_ON;
              idx        <= idx + 4'd1;
              show_valid <= 1'b1;
              show_idx   <= pattern[idx + 4'd1];
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_CLR: begin
          state      <= S_CAPTURE;
          cap_enable <= 1'b1;
          cnt        <= '0;
        end
        // cap_done is tested first so it wins over a timeout in the same cycle.
        S_CAPTURE: begin
          if (cap_done) begin
            state      <= S_CHECK;
            cap_enable <= 1'b0;
            idx        <= '0;
          end else if (cnt == TO_LAST) begin
            state      <= S_FAIL;
            cap_enable <= 1'b0;
            fail       <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_CHECK: begin
          if (cap_slot[idx] != pattern[idx]) begin
            state <= S_FAIL;
            fail  <= 1'b1;
          end else if (idx == last_idx) begin
            state <= S_PASS;
            pass  <= 1'b1;
            score <= (score == 8'hFF) ? score : score + 8'd1;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        S_PASS, S_FAIL: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          idx   <= '0;
          cnt   <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_controller.sv
// Directed self-checking bench for game_controller with SHOW_ON=2, SHOW_OFF=1, TIMEOUT=16.
// Expected patterns come from an independent LFSR model written from the tap list.
module tb_game_controller;

  localparam int SHOW_ON_C  = 2;
  localparam int SHOW_OFF_C = 1;
  localparam int TIMEOUT_C  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start = 1'b0;
  logic [2:0]  level = '0;
  logic [15:0] seed = '0;
  logic [47:0] cap_data = '0;
  logic        cap_done = 1'b0;
  logic        cap_enable, cap_clr_n, show_valid, busy, pass, fail;
  logic [2:0]  show_idx;
  logic [7:0]  score;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  game_controller #(
    .SHOW_ON  (SHOW_ON_C),
    .SHOW_OFF (SHOW_OFF_C),
    .TIMEOUT  (TIMEOUT_C)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .level      (level),
    .seed       (seed),
    .cap_data   (cap_data),
    .cap_done   (cap_done),
    .cap_enable (cap_enable),
    .cap_clr_n  (cap_clr_n),
    .show_valid (show_valid),
    .show_idx   (show_idx),
    .busy       (busy),
    .pass       (pass),
    .fail       (fail),
    .score      (score)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model_step(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  function automatic logic [47:0] model_caps(input logic [15:0] sd, input int len);
    logic [15:0] v;
    logic [47:0] c;
    v = (sd == 16'h0000) ? 16'hACE1 : sd;
    c = '0;
    for (int k = 0; k < len; k++) begin
      v = model_step(v);
      c[3*k +: 3] = v[2:0];
    end
    return c;
  endfunction

  task automatic start_round(input logic [2:0] lv, input logic [15:0] sd);
    level = lv;
    seed  = sd;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Walks GEN and the whole display phase, ending at the first CAPTURE cycle.
  task automatic run_show_phase(input logic [47:0] pat, input int len, input int gen_done);
    int n, w, g;
    n = gen_done;
    while (!show_valid && n < 100) begin tick(); n++; end
    compared++;
    if (n !== len) begin
      mismatched++;
      $display("[TB] FAIL gen_cycles: got %0d, want %0d", n, len);
    end
    for (int e = 0; e < len; e++) begin
      compared++;
      if (show_idx !== pat[3*e +: 3]) begin
        mismatched++;
        $display("[TB] FAIL show_idx[%0d]: got %0d, want %0d", e, show_idx, pat[3*e +: 3]);
      end
      w = 0;
      while (show_valid && w < 50) begin tick(); w++; end
      compared++;
      if (w !== SHOW_ON_C) begin
        mismatched++;
        $display("[TB] FAIL show_width[%0d]: got %0d, want %0d", e, w, SHOW_ON_C);
      end
      g = 0;
      while (!show_valid && cap_clr_n && g < 50) begin tick(); g++; end
      compared++;
      if (g !== SHOW_OFF_C) begin
        mismatched++;
        $display("[TB] FAIL show_gap[%0d]: got %0d, want %0d", e, g, SHOW_OFF_C);
      end
    end
    compared++;
    if (cap_clr_n !== 1'b0 || cap_enable !== 1'b0 || busy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL clr_state: got clr_n=%b en=%b busy=%b, want 0 0 1", cap_clr_n, cap_enable, busy);
    end
    tick();
    compared++;
    if (cap_clr_n !== 1'b1 || cap_enable !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL capture_entry: got clr_n=%b en=%b, want 1 1", cap_clr_n, cap_enable);
    end
  endtask

  task automatic run_capture_check(input logic [47:0] data, input int done_delay, input int exp_check,
                                   input logic exp_pass, input logic [7:0] exp_score);
    int n;
    cap_data = data;
    for (int i = 0; i < done_delay; i++) tick();
    compared++;
    if (cap_enable !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL capture_enable: got %b, want 1", cap_enable);
    end
    cap_done = 1'b1;
    tick();
    cap_done = 1'b0;
    compared++;
    if (cap_enable !== 1'b0 || pass !== 1'b0 || fail !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL check_entry: got en=%b pass=%b fail=%b, want 0 0 0", cap_enable, pass, fail);
    end
    n = 0;
    while (!pass && !fail && n < 100) begin tick(); n++; end
    compared++;
    if (n !== exp_check) begin
      mismatched++;
      $display("[TB] FAIL check_cycles: got %0d, want %0d", n, exp_check);
    end
    compared++;
    if (pass !== exp_pass || fail !== ~exp_pass) begin
      mismatched++;
      $display("[TB] FAIL outcome: got pass=%b fail=%b, want pass=%b", pass, fail, exp_pass);
    end
    compared++;
    if (score !== exp_score) begin
      mismatched++;
      $display("[TB] FAIL score: got %0d, want %0d", score, exp_score);
    end
    tick();
    compared++;
    if (busy !== 1'b0 || pass !== 1'b0 || fail !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL back_to_idle: got busy=%b pass=%b fail=%b, want 0 0 0", busy, pass, fail);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    tick();
    tick();
    compared++;
    if ({cap_enable, cap_clr_n, show_valid, show_idx, busy, pass, fail, score} !== 16'h0000) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got en=%b clr_n=%b sv=%b idx=%0d busy=%b p=%b f=%b score=%0d, want all 0",
               cap_enable, cap_clr_n, show_valid, show_idx, busy, pass, fail, score);
    end
    rst = 1'b1;
    tick();
    compared++;
    if (cap_clr_n !== 1'b1 || busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL after_reset: got clr_n=%b busy=%b, want 1 0", cap_clr_n, busy);
    end
  endtask

  task automatic test_ignored_start();
    logic [2:0] bad_levels [3];
    bad_levels = '{3'd0, 3'd4, 3'd7};
    for (int i = 0; i < 3; i++) begin
      start_round(bad_levels[i], 16'h1234);
      tick();
      compared++;
      if (busy !== 1'b0 || show_valid !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL ignored_level_%0d: got busy=%b, want 0", bad_levels[i], busy);
      end
    end
  endtask

  task automatic test_show_and_pass();
    logic [47:0] pat;
    pat = model_caps(16'h0001, 8);
    start_round(3'd1, 16'h0001);
    run_show_phase(pat, 8, 0);
    run_capture_check(pat | 48'hFFFFFF000000, 5, 8, 1'b1, 8'd1);
  endtask

  task automatic test_mismatch();
    logic [47:0] pat, flip;
    pat  = model_caps(16'h1234, 16);
    flip = 48'h1 << 27;
    start_round(3'd3, 16'h1234);
    run_show_phase(pat, 16, 0);
    run_capture_check(pat ^ flip, 2, 10, 1'b0, 8'd1);
  endtask

  task automatic test_timeout();
    logic [47:0] pat;
    int n;
    pat = model_caps(16'hBEEF, 8);
    start_round(3'd1, 16'hBEEF);
    run_show_phase(pat, 8, 0);
    n = 0;
    while (!fail && n < 100) begin tick(); n++; end
    compared++;
    if (n !== TIMEOUT_C || pass !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL timeout_cycles: got %0d pass=%b, want %0d pass=0", n, pass, TIMEOUT_C);
    end
    compared++;
    if (score !== 8'd1) begin
      mismatched++;
      $display("[TB] FAIL timeout_score: got %0d, want 1", score);
    end
    tick();
  endtask

  task automatic test_timeout_edge();
    logic [47:0] pat;
    int n;
    pat = model_caps(16'h00F0, 12);
    start_round(3'd2, 16'h00F0);
    run_show_phase(pat, 12, 0);
    cap_data = pat;
    for (int i = 0; i < TIMEOUT_C - 1; i++) tick();
    cap_done = 1'b1;
    tick();
    cap_done = 1'b0;
    compared++;
    if (fail !== 1'b0 || cap_enable !== 1'b0 || busy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL done_beats_timeout: got fail=%b en=%b busy=%b, want 0 0 1", fail, cap_enable, busy);
    end
    n = 0;
    while (!pass && !fail && n < 100) begin tick(); n++; end
    compared++;
    if (n !== 12 || pass !== 1'b1 || score !== 8'd2) begin
      mismatched++;
      $display("[TB] FAIL edge_round: got cycles=%0d pass=%b score=%0d, want 12 1 2", n, pass, score);
    end
    tick();
  endtask

  task automatic test_zero_seed();
    logic [47:0] pat;
    pat = model_caps(16'h0000, 8);
    start_round(3'd1, 16'h0000);
    run_show_phase(pat, 8, 0);
    run_capture_check(pat, 0, 8, 1'b1, 8'd3);
  endtask

  task automatic test_start_while_busy();
    logic [47:0] pat;
    pat = model_caps(16'h5A5A, 8);
    start_round(3'd1, 16'h5A5A);
    start_round(3'd3, 16'h1111);
    run_show_phase(pat, 8, 1);
    run_capture_check(pat, 1, 8, 1'b1, 8'd4);
  endtask

  task automatic test_reset_mid_show();
    logic [47:0] pat;
    start_round(3'd1, 16'h0777);
    for (int i = 0; i < 9; i++) tick();
    compared++;
    if (show_valid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL pre_reset_show: got %b, want 1", show_valid);
    end
    #2;
    rst = 1'b0;
    #1;
    compared++;
    if (show_valid !== 1'b0 || show_idx !== 3'd0 || busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL async_reset_show: got sv=%b idx=%0d busy=%b, want 0 0 0", show_valid, show_idx, busy);
    end
    compared++;
    if (cap_enable !== 1'b0 || cap_clr_n !== 1'b0 || pass !== 1'b0 || fail !== 1'b0 || score !== 8'd0) begin
      mismatched++;
      $display("[TB] FAIL async_reset_ctrl: got en=%b clr_n=%b p=%b f=%b score=%0d, want 0 0 0 0 0",
               cap_enable, cap_clr_n, pass, fail, score);
    end
    tick();
    rst = 1'b1;
    pat = model_caps(16'h0777, 8);
    start_round(3'd1, 16'h0777);
    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL first_start_after_reset: got busy=%b, want 1", busy);
    end
    run_show_phase(pat, 8, 0);
    run_capture_check(pat, 3, 8, 1'b1, 8'd1);
  endtask

  task automatic test_saturation();
    logic [47:0] pat;
    logic [15:0] sd;
    int n, bad;
    bad = 0;
    for (int r = 0; r < 255; r++) begin
      sd  = 16'(r + 7);
      pat = model_caps(sd, 8);
      start_round(3'd1, sd);
      cap_data = pat;
      n = 0;
      while (!cap_enable && n < 200) begin tick(); n++; end
      cap_done = 1'b1;
      tick();
      cap_done = 1'b0;
      n = 0;
      while (!pass && !fail && n < 50) begin tick(); n++; end
      if (pass !== 1'b1) bad++;
      if (r == 253) begin
        compared++;
        if (score !== 8'd255) begin
          mismatched++;
          $display("[TB] FAIL score_reach_255: got %0d, want 255", score);
        end
      end
      if (r == 254) begin
        compared++;
        if (score !== 8'd255) begin
          mismatched++;
          $display("[TB] FAIL score_saturate: got %0d, want 255", score);
        end
      end
      tick();
    end
    compared++;
    if (bad !== 0) begin
      mismatched++;
      $display("[TB] FAIL saturation_rounds: got %0d non-passing rounds, want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_ignored_start();
    test_show_and_pass();
    test_mismatch();
    test_timeout();
    test_timeout_edge();
    test_zero_seed();
    test_start_while_busy();
    test_reset_mid_show();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
